// File: rtl/osecpu_run_ctrl_pkg.sv
// Shared OSECPU run-control definitions: CR bit positions, result codes,
// sequencer states and the captured-result bundle.
package osecpu_run_ctrl_pkg;

    localparam int BIT_CR_HLT = 0;

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_HALT    = 2'b01;
    localparam logic [1:0] RES_TIMEOUT = 2'b10;
    localparam logic [1:0] RES_ABORT   = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RESET = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [1:0]  code;
        logic [31:0] dr;
        logic [15:0] pc;
        logic [31:0] cycles;
    } run_res_t;

    // Termination priority: halt beats abort beats timeout.
    function automatic logic [1:0] term_code(input logic halt, input logic abort);
        if (halt) begin
            return RES_HALT;
        end else if (abort) begin
            return RES_ABORT;
        end
        return RES_TIMEOUT;
    endfunction

endpackage

// File: rtl/osecpu_run_ctrl_sat_counter32.sv
// 32-bit saturating event counter with synchronous clear; shared with the
// core's performance counters.
module sat_counter32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    output logic [31:0] value
);

    logic [31:0] value_q;
    logic [31:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (enable && value_q != 32'hFFFF_FFFF) begin
            value_d = value_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/osecpu_run_ctrl.sv
// OSECPU run sequencer: holds the core in reset, launches a run, counts
// cycles and captures DR/PC/cycles on halt, watchdog timeout or abort.
module osecpu_run_ctrl
    import osecpu_run_ctrl_pkg::*;
#(
    parameter int RST_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] cycle_limit,
    output logic        cpu_reset,
    input  logic [31:0] cpu_dr,
    input  logic [7:0]  cpu_cr,
    input  logic [15:0] cpu_pc,
    output logic        busy,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [1:0]  res_code,
    output logic [31:0] res_dr,
    output logic [15:0] res_pc,
    output logic [31:0] res_cycles
);

    localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  rst_cnt_q, rst_cnt_d;
    logic [31:0] limit_q, limit_d;
    run_res_t    res_q, res_d;
    logic        cpu_reset_q, cpu_reset_d;
    logic        busy_q, busy_d;
    logic        res_valid_q, res_valid_d;

    logic        cnt_en;
    logic        cnt_clr;
    logic [31:0] cnt_val;
    logic        halt;
    logic        timeout;
    logic        cr_unused;

    assign halt      = cpu_cr[BIT_CR_HLT];
    assign timeout   = (limit_q != '0) && (cnt_val == limit_q);
    assign cr_unused = ^cpu_cr;

    sat_counter32 u_cycles (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clr),
        .enable (cnt_en),
        .value  (cnt_val)
    );

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        limit_d   = limit_q;
        res_d     = res_q;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    limit_d   = cycle_limit;
                    rst_cnt_d = '0;
                    cnt_clr   = 1'b1;
                    state_d   = ST_RESET;
                end
            end
            ST_RESET: begin
                if (abort) begin
                    res_d   = '{RES_ABORT, cpu_dr, cpu_pc, 32'd0};
                    state_d = ST_DONE;
                end else if (rst_cnt_q == RST_LAST) begin
                    // First RUN cycle sees the counter at 1.
                    cnt_en  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + 8'd1;
                end
            end
            ST_RUN: begin
                if (halt || abort || timeout) begin
                    res_d   = '{term_code(halt, abort), cpu_dr, cpu_pc, cnt_val};
                    state_d = ST_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                if (res_valid_q && res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cpu_reset_d = (state_d != ST_RUN);
        busy_d      = (state_d == ST_RESET) || (state_d == ST_RUN);
        res_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rst_cnt_q   <= '0;
            limit_q     <= '0;
            res_q       <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            limit_q     <= limit_d;
            res_q       <= res_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign res_valid  = res_valid_q;
    assign res_code   = res_q.code;
    assign res_dr     = res_q.dr;
    assign res_pc     = res_q.pc;
    assign res_cycles = res_q.cycles;

endmodule
